// File: rtl/serial_bit_source.sv
// Parallel-in, serial-out bit source feeding the sequence detector's x input.
// Words load through valid/ready; back-to-back loads chain with no idle bit.
module serial_bit_source #(
   parameter int WIDTH      = 8,
   parameter bit MSB_FIRST  = 1'b1,
   parameter bit IDLE_LEVEL = 1'b0
) (
   input  logic             clk,
   input  logic             rst,
   input  logic [WIDTH-1:0] din,
   input  logic             load_valid,
   output logic             load_ready,
   input  logic             shift_en,
   output logic             x,
   output logic             x_valid,
   output logic             busy,
   output logic             done
);
   localparam int            CW   = (WIDTH > 1) ? $clog2(WIDTH) : 1;
   localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

   typedef enum logic {IDLE, SHIFT} state_t;

   state_t           state, state_n;
   logic [WIDTH-1:0] sreg, sreg_n;
   logic [CW-1:0]    cnt, cnt_n;
   logic             x_n, x_valid_n;
   logic             at_last, accept;

   always_ff @(posedge clk) begin
      if (rst) begin
         state   <= IDLE;
         sreg    <= '0;
         cnt     <= '0;
         x       <= IDLE_LEVEL;
         x_valid <= 1'b0;
      end else begin
         state   <= state_n;
         sreg    <= sreg_n;
         cnt     <= cnt_n;
         x       <= x_n;
         x_valid <= x_valid_n;
      end
   end

   assign at_last    = (cnt == LAST);
   assign load_ready = (state == IDLE) | ((state == SHIFT) & at_last & shift_en);
   assign accept     = load_valid & load_ready;
   assign busy       = (state == SHIFT);
   assign done       = x_valid & at_last;

   // sreg holds the bits not yet on x, with the next one parked at the end
   // that is popped (MSB end or LSB end depending on order).
   always_comb begin
      state_n   = state;
      sreg_n    = sreg;
      cnt_n     = cnt;
      x_n       = x;
      x_valid_n = x_valid;
      if (accept) begin
         state_n   = SHIFT;
         cnt_n     = '0;
         x_valid_n = 1'b1;
         if (MSB_FIRST) begin
            x_n    = din[WIDTH-1];
            sreg_n = {din[WIDTH-2:0], 1'b0};
         end else begin
            x_n    = din[0];
            sreg_n = {1'b0, din[WIDTH-1:1]};
         end
      end else if (state == SHIFT && shift_en) begin
         if (at_last) begin
            state_n   = IDLE;
            cnt_n     = '0;
            x_n       = IDLE_LEVEL;
            x_valid_n = 1'b0;
         end else begin
            cnt_n = cnt + CW'(1);
            if (MSB_FIRST) begin
               x_n    = sreg[WIDTH-1];
               sreg_n = {sreg[WIDTH-2:0], 1'b0};
            end else begin
               x_n    = sreg[0];
               sreg_n = {1'b0, sreg[WIDTH-1:1]};
            end
         end
      end
   end
endmodule

// File: doc/serial_bit_source.md
Name: serial_bit_source

Overview:
- Parallel-in, serial-out bit source that drives the `x` input of the sequence detector stage.
- Accepts a WIDTH-bit word through a valid/ready load handshake.
- Emits the word one bit per enabled clock edge on `x`, with `x_valid` qualifying every bit.
- Supports back-to-back words with no idle gap, so the detector sees a continuous stream.

Parameters:
- WIDTH, 8, bits per word (legal range 2..32).
- MSB_FIRST, 1, 1 = din[WIDTH-1] is sent first; 0 = din[0] is sent first.
- IDLE_LEVEL, 0, value driven on `x` whenever no word is being sent.

Ports:
- clk  input  1  rising-edge clock.
- rst  input  1  synchronous, active-high reset.
- din  input  WIDTH  word to serialize; sampled only on an accepted load.
- load_valid  input  1  producer has a word on din.
- load_ready  output  1  block can accept a word this cycle (combinational).
- shift_en  input  1  1 = advance one bit this edge; 0 = hold the current bit.
- x  output  1  serial data to the detector (registered).
- x_valid  output  1  x carries a real data bit (registered).
- busy  output  1  a word is in flight.
- done  output  1  high while the last bit of a word is on x (one bit-time).

Behaviour:
- Interface: one clock `clk`; reset `rst` is synchronous and active-high.
- Reset values: state=IDLE, shift register=0, bit counter=0, x=IDLE_LEVEL, x_valid=0, busy=0, done=0.
  - load_ready is 1 on the first cycle after reset.
- Reset mid-word: the next edge drops the word and forces all reset values. No partial bits are emitted after that edge.
- FSM has 2 states: IDLE and SHIFT.
- Counter `cnt` is $clog2(WIDTH) bits wide and indexes the bit currently on x (0..WIDTH-1).
- load_ready = (state==IDLE) | (state==SHIFT & cnt==WIDTH-1 & shift_en).
- Accept: load_valid & load_ready at a rising edge.
  - din is captured; state goes to SHIFT and cnt goes to 0.
  - x takes the first bit and x_valid goes to 1 at that same edge.
  - Latency from accept edge to first bit on x: 0 cycles (the bit is visible right after the edge).
- SHIFT with shift_en=1 and cnt<WIDTH-1: cnt+1; x takes the next bit in MSB_FIRST order.
- SHIFT with shift_en=0: x, x_valid, cnt and the shift register all hold. load_ready=0 even when cnt==WIDTH-1.
- SHIFT with shift_en=1, cnt==WIDTH-1:
  - If load_valid=1: the new word is accepted; x takes its first bit on the same edge. No gap cycle; x_valid stays 1.
  - If load_valid=0: state goes to IDLE, x=IDLE_LEVEL, x_valid=0.
- A word of WIDTH bits occupies exactly WIDTH enabled edges on x.
- busy = (state==SHIFT).
- done = x_valid & (cnt==WIDTH-1), decoded from registers. It stays high across shift_en=0 stalls.
- load_valid while load_ready=0 is ignored; din is not sampled.
- Outputs change only on rising clk edges, except load_ready, which is combinational from state, cnt and shift_en.

Test Plan:
- Reset then idle:
  - Stimulus: rst=1 for 2 cycles, then 0, with load_valid=0.
  - Required: x=0, x_valid=0, busy=0, load_ready=1 on every cycle.
- Single word, MSB first (WIDTH=8):
  - Stimulus: din=8'b11110110, one load pulse, shift_en=1.
  - Required: x = 1,1,1,1,0,1,1,0 on 8 consecutive cycles with x_valid=1; done high only on the 8th bit; then x=0, x_valid=0, busy=0.
- Back-to-back words:
  - Stimulus: din=8'hF6 then 8'h37, load_valid held high.
  - Required: 16 contiguous x_valid cycles with no gap; second word's first bit (0) immediately follows the first word's last bit (0); load_ready=1 only on the 8th bit of each word.
- Stall:
  - Stimulus: shift_en=0 for 3 cycles while bit 3 of 8'hF6 is on x.
  - Required: x=1 and cnt=3 are held for 3 cycles; the word completes 3 cycles later than in the unstalled case; total of 8 distinct bits, none repeated or skipped.
- LSB-first variant:
  - Stimulus: MSB_FIRST=0, din=8'b00000111.
  - Required: x = 1,1,1,0,0,0,0,0.
- Reset mid-word:
  - Stimulus: rst=1 while bit 4 of 8'hF6 is on x.
  - Required: at the next edge x=0, x_valid=0, busy=0, load_ready=1; no remaining bits are emitted.
  - Follow-up: a new load after reset sends a full word from bit 0.
